// File: rtl/disp_src_scheduler_if.sv
// Source/request bus and display-pin bundle for disp_src_scheduler.
// The master side drives the sources and controls; the slave side is the scheduler itself.
interface disp_src_scheduler_if;
  logic [7:0] src_a;
  logic [7:0] src_b;
  logic [7:0] src_r;
  logic [2:0] req;
  logic       mode;
  logic [1:0] man_sel;
  logic       bin_mode;
  logic [6:0] seg;
  logic [3:0] an;
  logic [1:0] cur_src;
  logic       busy;

  modport master (
    output src_a, src_b, src_r, req, mode, man_sel, bin_mode,
    input  seg, an, cur_src, busy
  );

  modport slave (
    input  src_a, src_b, src_r, req, mode, man_sel, bin_mode,
    output seg, an, cur_src, busy
  );
endinterface

// File: rtl/disp_src_scheduler.sv
// Shares the 4-digit seven-segment display between operand A, operand B and the ALU result.
// Optional macro DISP_CHANGE_DETECT_EN: re-latch the shown source whenever its input changes.
//
// state | meaning
// IDLE  | nothing granted, display blanked
// LATCH | sample granted source, sign and magnitude
// CONV  | 8 shift-add-3 iterations, digits committed on the last
// SHOW  | digits displayed, dwell timer running, re-arbitration point
module disp_src_scheduler #(
  parameter int DWELL_W = 26,
  parameter int SCAN_W  = 18
) (
  input logic clk,
  input logic rst_n,
  disp_src_scheduler_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LATCH, CONV, SHOW} state_e;

  localparam logic [1:0] SRC_NONE  = 2'd3;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;

  state_e              state_q, state_d;
  logic [1:0]          cur_q, rr_q, gnt_idx;
  logic                grant, relatch;
  logic [DWELL_W-1:0]  dwell_q;
  logic [SCAN_W-1:0]   scan_q;
  logic [7:0]          bin_q, cur_val, abs_val, bin_nxt;
  logic [11:0]         bcd_q, bcd_adj, bcd_nxt;
  logic [19:0]         shift_val;
  logic [2:0]          cnt_q;
  logic                lat_sign_q;
  logic [3:0]          lat_raw_q;
  logic                dsp_sign_q;
  logic [3:0]          dsp_h_q, dsp_t_q, dsp_o_q, dsp_raw_q;
  logic [6:0]          seg_q, seg_d;
  logic [3:0]          an_q, an_d;
  logic [1:0]          digit_idx;
  logic [1:0]          rr_o0, rr_o1, rr_o2, rr_idx;
  logic                rr_hit, man_ok, cur_req;
`ifdef DISP_CHANGE_DETECT_EN
  logic [7:0]          lat_val_q;
`endif

  function automatic logic req_bit(input logic [2:0] r, input logic [1:0] i);
    case (i)
      2'd0:    return r[0];
      2'd1:    return r[1];
      2'd2:    return r[2];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return SEG_BLANK;
    endcase
  endfunction

  always_comb begin
    case (cur_q)
      2'd0:    cur_val = bus.src_a;
      2'd1:    cur_val = bus.src_b;
      2'd2:    cur_val = bus.src_r;
      default: cur_val = 8'd0;
    endcase
  end

  // -128 wraps to 8'h80, which reads as 128 unsigned
  assign abs_val = cur_val[7] ? (~cur_val + 8'd1) : cur_val;

  // Round-robin search order starts just after the last grant and ends on it
  always_comb begin
    case (rr_q)
      2'd0:    begin rr_o0 = 2'd1; rr_o1 = 2'd2; rr_o2 = 2'd0; end
      2'd1:    begin rr_o0 = 2'd2; rr_o1 = 2'd0; rr_o2 = 2'd1; end
      default: begin rr_o0 = 2'd0; rr_o1 = 2'd1; rr_o2 = 2'd2; end
    endcase
    if (req_bit(bus.req, rr_o0))      rr_idx = rr_o0;
    else if (req_bit(bus.req, rr_o1)) rr_idx = rr_o1;
    else                              rr_idx = rr_o2;
  end

  assign rr_hit  = |bus.req;
  assign man_ok  = (bus.man_sel != SRC_NONE) && req_bit(bus.req, bus.man_sel);
  assign cur_req = req_bit(bus.req, cur_q);

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    relatch = 1'b0;
    gnt_idx = cur_q;
    case (state_q)
      IDLE: begin
        if (!bus.mode) begin
          if (rr_hit) begin
            grant   = 1'b1;
            gnt_idx = rr_idx;
          end
        end else if (man_ok) begin
          grant   = 1'b1;
          gnt_idx = bus.man_sel;
        end
      end
      LATCH: state_d = CONV;
      CONV: begin
        if (cnt_q == 3'd7) state_d = SHOW;
      end
      SHOW: begin
        if (!cur_req || (bus.mode && (bus.man_sel != cur_q))) begin
          if (!bus.mode && rr_hit) begin
            grant   = 1'b1;
            gnt_idx = rr_idx;
          end else if (bus.mode && man_ok) begin
            grant   = 1'b1;
            gnt_idx = bus.man_sel;
          end else begin
            state_d = IDLE;
          end
        end else if (!bus.mode && (dwell_q == '0)) begin
          grant   = 1'b1;
          gnt_idx = rr_idx;
        end
`ifdef DISP_CHANGE_DETECT_EN
        else if (cur_val != lat_val_q) begin
          relatch = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    if (grant || relatch) state_d = LATCH;
  end

  assign bcd_adj   = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
  assign shift_val = {bcd_adj, bin_q} << 1;
  assign bcd_nxt   = shift_val[19:8];
  assign bin_nxt   = shift_val[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cur_q      <= SRC_NONE;
      rr_q       <= 2'd2;
      dwell_q    <= '0;
      scan_q     <= '0;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      lat_sign_q <= 1'b0;
      lat_raw_q  <= '0;
      dsp_sign_q <= 1'b0;
      dsp_h_q    <= '0;
      dsp_t_q    <= '0;
      dsp_o_q    <= '0;
      dsp_raw_q  <= '0;
      seg_q      <= SEG_BLANK;
      an_q       <= 4'hF;
`ifdef DISP_CHANGE_DETECT_EN
      lat_val_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      scan_q  <= scan_q + SCAN_W'(1);
      seg_q   <= seg_d;
      an_q    <= an_d;
      // A change-detect re-latch keeps the running dwell so the slot length is unchanged
      if (grant) begin
        cur_q   <= gnt_idx;
        rr_q    <= gnt_idx;
        dwell_q <= '1;
      end else if (state_q == SHOW) begin
        dwell_q <= dwell_q - DWELL_W'(1);
      end
      if (state_d == IDLE) cur_q <= SRC_NONE;
      if (state_q == LATCH) begin
        lat_sign_q <= cur_val[7];
        lat_raw_q  <= cur_val[3:0];
        bin_q      <= abs_val;
        bcd_q      <= '0;
        cnt_q      <= '0;
`ifdef DISP_CHANGE_DETECT_EN
        lat_val_q  <= cur_val;
`endif
      end
      if (state_q == CONV) begin
        bcd_q <= bcd_nxt;
        bin_q <= bin_nxt;
        cnt_q <= cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          dsp_h_q    <= bcd_nxt[11:8];
          dsp_t_q    <= bcd_nxt[7:4];
          dsp_o_q    <= bcd_nxt[3:0];
          dsp_sign_q <= lat_sign_q;
          dsp_raw_q  <= lat_raw_q;
        end
      end
    end
  end

  assign digit_idx = scan_q[SCAN_W-1 -: 2];

  always_comb begin
    seg_d = SEG_BLANK;
    an_d  = 4'hF;
    if (state_d != IDLE) begin
      an_d = ~(4'b0001 << digit_idx);
      if (bus.bin_mode) begin
        seg_d = seg_digit({3'b000, dsp_raw_q[digit_idx]});
      end else begin
        case (digit_idx)
          2'd3: seg_d = dsp_sign_q ? SEG_MINUS : SEG_BLANK;
          2'd2: if (dsp_h_q != 4'd0) seg_d = seg_digit(dsp_h_q);
          2'd1: if ((dsp_h_q != 4'd0) || (dsp_t_q != 4'd0)) seg_d = seg_digit(dsp_t_q);
          default: seg_d = seg_digit(dsp_o_q);
        endcase
      end
    end
  end

  assign bus.seg     = seg_q;
  assign bus.an      = an_q;
  assign bus.cur_src = cur_q;
  assign bus.busy    = (state_q == LATCH) || (state_q == CONV);

endmodule

// File: tb/tb_disp_src_scheduler.sv
// Randomized self-checking bench for disp_src_scheduler with short dwell and scan counters.
// Expected digits come from integer arithmetic on the source values; grants from a simple pointer model.
module tb_disp_src_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   busy_seen = 0;
  int   ptr;

  disp_src_scheduler_if dif();

  disp_src_scheduler #(.DWELL_W(4), .SCAN_W(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (dif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] dig(input int d);
    case (d)
      0: return 7'h40; 1: return 7'h79; 2: return 7'h24; 3: return 7'h30; 4: return 7'h19;
      5: return 7'h12; 6: return 7'h02; 7: return 7'h78; 8: return 7'h00; 9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input logic [7:0] v, input bit b, input int pos);
    int vi, a, h, t, o;
    vi = int'(v);
    a  = (vi >= 128) ? 256 - vi : vi;
    h  = a / 100;
    t  = (a / 10) % 10;
    o  = a % 10;
    if (b) return dig(v[pos] ? 1 : 0);
    case (pos)
      3: return (vi >= 128) ? 7'h3F : 7'h7F;
      2: return (h != 0) ? dig(h) : 7'h7F;
      1: return ((h != 0) || (t != 0)) ? dig(t) : 7'h7F;
      default: return dig(o);
    endcase
  endfunction

  function automatic int next_src(input int p, input logic [2:0] r);
    for (int i = 1; i <= 3; i++) begin
      if (r[(p + i) % 3]) return (p + i) % 3;
    end
    return 3;
  endfunction

  task automatic wait_busy(input logic lvl, input int budget, input string tag);
    int k = 0;
    while (dif.busy !== lvl && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (dif.busy !== lvl) check({tag, "_timeout"}, dif.busy, lvl);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (dif.busy === 1'b1 && n < 30) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic check_digits(input string tag, input logic [7:0] v, input bit b, input int n);
    int pos;
    for (int i = 0; i < n; i++) begin
      case (dif.an)
        4'b1110: pos = 0;
        4'b1101: pos = 1;
        4'b1011: pos = 2;
        4'b0111: pos = 3;
        default: pos = -1;
      endcase
      if (dif.busy === 1'b1) busy_seen++;
      check({tag, "_an"}, (pos >= 0), 1'b1);
      if (pos >= 0) check({tag, "_seg"}, dif.seg, exp_seg(v, b, pos));
      @(negedge clk);
    end
  endtask

  task automatic slot(input string tag, input int exp_cur, input logic [7:0] v, input bit b,
                      input int ncheck, output int rise_cyc);
    int n;
    wait_busy(1'b1, 80, tag);
    rise_cyc = cyc;
    check({tag, "_cur"}, dif.cur_src, exp_cur);
    count_busy(n);
    check({tag, "_busylen"}, n, 9);
    @(negedge clk);
    check_digits(tag, v, b, ncheck);
  endtask

  task automatic go_idle();
    int k = 0;
    dif.req = 3'b000;
    while (dif.cur_src !== 2'd3 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("idle_cur", dif.cur_src, 2'd3);
    @(negedge clk);
    check("idle_an", dif.an, 4'hF);
  endtask

  initial begin
    int r0, r1, n, g;
    logic [7:0] vals [3];
    logic [2:0] rq;
    bit bm;

    dif.src_a = 8'd0; dif.src_b = 8'd0; dif.src_r = 8'd0;
    dif.req = 3'b000; dif.mode = 1'b0; dif.man_sel = 2'd3; dif.bin_mode = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_seg", dif.seg, 7'h7F);
    check("rst_an", dif.an, 4'hF);
    check("rst_cur", dif.cur_src, 2'd3);
    check("rst_busy", dif.busy, 1'b0);
    rst_n = 1'b1;

    // Reset in the middle of a conversion
    dif.src_a = 8'd77;
    dif.req = 3'b001;
    wait_busy(1'b1, 10, "pre_rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_seg", dif.seg, 7'h7F);
    check("midrst_an", dif.an, 4'hF);
    check("midrst_cur", dif.cur_src, 2'd3);
    check("midrst_busy", dif.busy, 1'b0);
    dif.src_a = 8'd5; dif.src_b = 8'hD6; dif.src_r = 8'h80;
    dif.req = 3'b111;
    @(negedge clk);
    rst_n = 1'b1;
    ptr = 2;

    // Auto round-robin A, B, R, A with slot spacing
    vals[0] = 8'd5; vals[1] = 8'hD6; vals[2] = 8'h80;
    r0 = 0;
    for (int k = 0; k < 4; k++) begin
      g = next_src(ptr, 3'b111);
      slot("rr", g, vals[g], 1'b0, 12, r1);
      if (k > 0) check("rr_period", r1 - r0, 25);
      r0 = r1;
      ptr = g;
    end
    check("rr_first_wrap", ptr, 0);

    // Single requester drops in SHOW
    go_idle();
    dif.src_b = 8'd100;
    dif.req = 3'b010;
    slot("b100", 1, 8'd100, 1'b0, 4, r1);
    dif.req = 3'b000;
    @(posedge clk);
    #1;
    check("drop_cur", dif.cur_src, 2'd3);
    check("drop_an", dif.an, 4'hF);
    check("drop_busy", dif.busy, 1'b0);
    @(negedge clk);

    // Manual R in binary, then decimal without reconversion
    dif.mode = 1'b1; dif.man_sel = 2'd2; dif.src_r = 8'h0B; dif.bin_mode = 1'b1;
    dif.req = 3'b100;
    slot("man_bin", 2, 8'h0B, 1'b1, 12, r1);
    dif.bin_mode = 1'b0;
    @(negedge clk);
    busy_seen = 0;
    check_digits("man_dec", 8'h0B, 1'b0, 12);
    check("man_dec_nobusy", busy_seen, 0);

    // Manual select switched during conversion
    go_idle();
    dif.man_sel = 2'd0; dif.src_a = 8'h21; dif.src_b = 8'h9C;
    dif.req = 3'b011;
    wait_busy(1'b1, 10, "sw_a");
    check("sw_a_cur", dif.cur_src, 2'd0);
    repeat (2) @(negedge clk);
    dif.man_sel = 2'd1;
    count_busy(n);
    check("sw_a_busylen", n + 2, 9);
    wait_busy(1'b1, 3, "sw_b");
    check("sw_b_cur", dif.cur_src, 2'd1);
    check_digits("sw_show_a", 8'h21, 1'b0, 8);
    count_busy(n);
    check("sw_b_busylen", n + 8, 9);
    @(negedge clk);
    check_digits("sw_show_b", 8'h9C, 1'b0, 12);

    // Source value changes while shown
    go_idle();
    dif.mode = 1'b0; dif.src_a = 8'd3;
    dif.req = 3'b001;
    slot("chg3", 0, 8'd3, 1'b0, 4, r1);
    dif.src_a = 8'd4;
`ifdef DISP_CHANGE_DETECT_EN
    wait_busy(1'b1, 3, "chg_relatch");
    check("chg_cur", dif.cur_src, 2'd0);
    count_busy(n);
    check("chg_busylen", n, 9);
    @(negedge clk);
    check_digits("chg4", 8'd4, 1'b0, 4);
`else
    busy_seen = 0;
    check_digits("chg_hold3", 8'd3, 1'b0, 8);
    check("chg_nobusy", busy_seen, 0);
`endif
    slot("chg_next", 0, 8'd4, 1'b0, 4, r1);

    // Randomized auto-mode runs from a known pointer
    go_idle();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ptr = 2;
    for (int it = 0; it < 6; it++) begin
      go_idle();
      vals[0] = 8'($urandom); vals[1] = 8'($urandom); vals[2] = 8'($urandom);
      rq = 3'($urandom_range(1, 7));
      bm = 1'($urandom);
      dif.src_a = vals[0]; dif.src_b = vals[1]; dif.src_r = vals[2];
      dif.bin_mode = bm;
      dif.req = rq;
      r0 = 0;
      for (int k = 0; k < 4; k++) begin
        g = next_src(ptr, rq);
        slot("rand", g, vals[g], bm, 12, r1);
        if (k > 0) check("rand_period", r1 - r0, 25);
        r0 = r1;
        ptr = g;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/disp_src_scheduler.md
Name: disp_src_scheduler

Overview:
- Shares the four-digit seven-segment display between three 8-bit sources: operand A, operand B and the ALU result.
- Grants one source at a time, either round-robin with a fixed dwell time or by manual selection.
- Latches the granted value and converts it to sign plus BCD with a sequential 8-cycle shift-add-3 converter.
- Drives the time-multiplexed tube scan. Sits between the ALU core and the board display pins.

Parameters:
- DWELL_W, 26: dwell counter width; each auto-mode slot lasts 2^DWELL_W cycles after conversion completes.
- SCAN_W, 18: scan counter width; bits [SCAN_W-1:SCAN_W-2] select the active digit.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- src_a  in  8  operand A, two's complement
- src_b  in  8  operand B, two's complement
- src_r  in  8  ALU result, two's complement
- req  in  3  per-source display request; bit0=A, bit1=B, bit2=R
- mode  in  1  0: round-robin auto; 1: manual
- man_sel  in  2  manual source select; 0=A, 1=B, 2=R, 3=blank
- bin_mode  in  1  0: signed decimal; 1: low nibble as 4 binary digits
- seg  out  7  segments a..g, seg[0]=a, active-low
- an  out  4  digit anodes, active-low, an[3] leftmost
- cur_src  out  2  source currently shown; 3 when none
- busy  out  1  high during LATCH/CONV

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; seg=7'h7F; an=4'hF; cur_src=3; busy=0.
  - Digit registers cleared; counters cleared.
  - RR pointer=2, so the first auto grant goes to A.
- FSM states: IDLE, LATCH, CONV, SHOW.
- IDLE: display blank (an=4'hF).
  - Auto mode: leave when req!=0.
  - Manual mode: leave when man_sel!=3 and req[man_sel]=1.
  - Transition goes to LATCH.
- LATCH (1 cycle):
  - Register the granted value and sign=value[7].
  - abs=two's-complement magnitude; -128 gives 128.
  - Update cur_src; busy=1.
- CONV (exactly 8 cycles): one shift-add-3 iteration per cycle into a 12-bit BCD register.
  - On the 8th cycle, commit hundreds, tens, ones, sign and raw nibble to the display registers in a single cycle.
  - Previous digits stay displayed throughout LATCH/CONV (no flicker, no partial values).
  - Latency from grant to new digits: 9 cycles.
- SHOW: busy=0; dwell counter runs.
  - Auto mode, counter wraps to 0: advance to the next requesting index after the pointer (wrap 2 to 0), then LATCH.
  - Auto mode, only the current source is requesting: it is re-latched, which refreshes the value.
  - Manual mode: no dwell; hold until man_sel changes or req[cur] drops.
- Current request drops in SHOW: on the next cycle go to the next requester, or to IDLE if none.
- Source changes during LATCH/CONV:
  - The in-flight conversion completes.
  - Re-arbitration happens on the first SHOW cycle.
- mode toggled: takes effect at the next arbitration point.
- Digit mapping, decimal mode:
  - d3='-' (seg g only) if sign, else blank.
  - d2=hundreds, blanked when 0.
  - d1=tens, blanked when hundreds=0 and tens=0.
  - d0=ones, always shown.
- Digit mapping, bin_mode: d3..d0 = raw[3]..raw[0], each shown as '0' or '1'. bin_mode is applied combinationally and needs no reconversion.
- Scan counter: free-running; an is one-hot low per the selected digit. A blanked digit drives seg=7'h7F with its anode still active.
- Outputs are registered; seg/an change one cycle after the scan counter index changes.

Optional Feature:
- Macro: DISP_CHANGE_DETECT_EN.
- Defined:
  - In SHOW, the granted source input is compared against the latched value every cycle.
  - On mismatch, go to LATCH; the dwell counter is not reset, so the remaining dwell continues afterwards.
- Undefined: the value is sampled only at LATCH; later input changes appear only at the next grant.

Test Plan (DWELL_W=4, SCAN_W=4):
- Reset mid-CONV with src_a=8'd77: assert rst_n=0 -> seg=7F, an=F, cur_src=3, busy=0 immediately; after release, A is granted first.
- Auto mode, req=3'b111, A=8'd5, B=-8'd42 (8'hD6), R=8'd128 unsigned bits (-128) -> shows "   5", then "- 42"... then "-128" in order; each slot = 9+16 cycles; wraps back to A.
- req=3'b010, B=8'd100, then req[1] deasserted in SHOW -> next cycle IDLE, an=F, cur_src=3.
- Manual, man_sel=2, R=8'h0B, bin_mode=1 -> digits "1011"; toggling bin_mode=0 -> "  11" with no busy pulse.
- Manual, man_sel switched 0->1 while in CONV -> conversion of A completes and A is shown, then B is latched on the first SHOW cycle; busy is high for 9 cycles twice.
- DISP_CHANGE_DETECT_EN defined: A changes 3->4 in SHOW -> LATCH next cycle, "4" shown 9 cycles later; undefined: "3" persists until the slot ends.
